// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port round-robin SRAM arbiter.
// Read tags carry the requester id through the fixed-latency read path.
package sram_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned RD_LATENCY     = 2;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    rd;
        req_id_t id;
    } rd_tag_t;

    // Bit N set = grant port N; prio names the port favoured on contention.
    function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input req_id_t prio);
        logic [1:0] g;
        g[0] = v0 && (!v1 || (prio == 1'b0));
        g[1] = v1 && (!v0 || (prio == 1'b1));
        return g;
    endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Fixed-depth shift register of read tags; never stalls.
// Reports the oldest tag and whether any read will occupy a stage after the next edge.
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LATENCY
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o,
    output logic    inflight_o
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

    // The last stage drains on the coming edge, so only the incoming tag and
    // the stages that shift onward are counted.
    always_comb begin
        inflight_o = tag_i.rd;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            inflight_o = inflight_o | stage_q[i].rd;
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port byte SRAM wrapper between two requesters,
// with registered SRAM controls and tag-tracked read responses.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned RD_LATENCY = sram_arb_pkg::RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [1:0]            gnt;
    logic                  accept;
    req_id_t               win_id;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    req_id_t               prio_q, prio_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_oe_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;

    rd_tag_t               tag_in;
    rd_tag_t               tag_last;
    logic                  rd_inflight;

    always_comb begin
        gnt       = rr_grant(req0_valid, req1_valid, prio_q);
        accept    = gnt[0] | gnt[1];
        win_id    = req_id_t'(gnt[1]);
        win_we    = gnt[1] ? req1_we    : req0_we;
        win_addr  = gnt[1] ? req1_addr  : req0_addr;
        win_wdata = gnt[1] ? req1_wdata : req0_wdata;
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        prio_d       = prio_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tag_in       = '0;
        if (accept) begin
            prio_d      = ~win_id;
            mem_we_d    = win_we;
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
            tag_in.rd   = ~win_we;
            tag_in.id   = win_id;
        end
        rsp0_valid_d = tag_last.rd && (tag_last.id == 1'b0);
        rsp1_valid_d = tag_last.rd && (tag_last.id == 1'b1);
    end

    sram_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_i      (tag_in),
        .tag_o      (tag_last),
        .inflight_o (rd_inflight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            mem_we_q     <= mem_we_d;
            mem_oe_q     <= rd_inflight;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_oe     = mem_oe_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_valid_q ? mem_rdata : '0;
    assign rsp1_rdata = rsp1_valid_q ? mem_rdata : '0;

endmodule
